vec_wb_collector: RTL and testbench
===================================

// Module: vec_wb_collector
// PURPOSE
//   Consumer end of the vector ALU lane interface. Receives the per-lane result chunks (vd, reg_index, done) from up to
//   NB_LANE_PORTS lanes, assembles them into one VLEN-bit destination register and hands it to the vector register
//   file write port over a valid/ready handshake. Sits between the lane array and the vreg file in the vector unit.
// PARAMETERS
//   VLEN          10'd128  vector register width in bits
//   LANE_WIDTH    3'b011   chunk width per lane = 2^LANE_WIDTH bits (8/16/32/64), equals the lanes' LANE_WIDTH
//   NB_LANE_PORTS 4        number of physical lane input ports (1..4)
//   TIMEOUT       1023     max COLLECT cycles before forced abort
// PORTS
//   clk           in   1                  clock, all logic on posedge
//   reset         in   1                  synchronous, active-high reset
//   start         in   1                  one-cycle pulse: begin collecting an instruction's result
//   cfg_vd_addr   in   5                  destination vreg number, sampled on accepted start
//   cfg_nb_lanes  in   2                  2^cfg_nb_lanes lanes active (lanes 0..2^n-1), sampled on accepted start
//   lane_valid    in   NB_LANE_PORTS      lane i presents a valid chunk this cycle
//   lane_vd       in   NB_LANE_PORTS*64   lane i result, bits [i*64 +: 64]; only low 2^LANE_WIDTH bits used
//   lane_idx      in   NB_LANE_PORTS*10   lane i destination bit offset, bits [i*10 +: 10]
//   lane_done     in   NB_LANE_PORTS      lane i has issued its last chunk
//   busy          out  1                  high in COLLECT and WRITE
//   wb_valid      out  1                  write-back request valid
//   wb_ready      in   1                  vreg file accepts write-back
//   wb_vd_addr    out  5                  destination vreg number
//   wb_data       out  VLEN               assembled result
//   err           out  1                  sticky error: out-of-range chunk, same-cycle collision, or timeout
// BEHAVIOUR
//   Reset (reset=1 at posedge): state IDLE; busy=0, wb_valid=0, wb_vd_addr=0, wb_data=0, err=0, done mask and
//     timeout counter cleared. Reset mid-COLLECT/WRITE abandons the operation; no write-back is issued.
//   CHUNK = 2^LANE_WIDTH bits. active mask A = lanes 0..(2^cfg_nb_lanes)-1, clipped to NB_LANE_PORTS.
//   IDLE: start=1 -> COLLECT next cycle; latch cfg_vd_addr, A; clear accumulator to 0, done_seen, counter, err.
//     start in COLLECT/WRITE is ignored (no effect on any state).
//   COLLECT, every cycle, for each lane i in A with lane_valid[i]:
//     - lane_idx+CHUNK <= VLEN: acc[lane_idx +: CHUNK] <= lane_vd[i*64 +: CHUNK]; other acc bits unchanged.
//     - else chunk dropped, err<=1.
//     - two lanes with overlapping ranges same cycle: higher lane number wins on overlap bits, err<=1.
//     - lane_valid/lane_done on lanes outside A ignored.
//     lane_done[i] (i in A) sets done_seen[i]; chunks are still accepted on the done cycle and the following one.
//     When done_seen covers A (including bits set this cycle) -> WRITE on the next cycle after that, i.e. exactly one
//     extra capture cycle after the last done.
//     Counter increments each COLLECT cycle; reaching TIMEOUT -> err<=1, IDLE, no write-back.
//   WRITE: wb_valid=1, wb_data=acc, wb_vd_addr=latched addr, all held stable until wb_ready=1.
//     Handshake (wb_valid & wb_ready at posedge) -> IDLE next cycle, wb_valid=0. wb_data keeps last value in IDLE.
//     Lane inputs ignored in WRITE.
//   busy=1 iff state != IDLE. err clears only on reset or accepted start.
//   Minimum latency: start -> first wb_valid = 3 cycles when all lanes done in first COLLECT cycle.
// TESTING
//   1 lane, LANE_WIDTH=3, VLEN=128: 16 chunks idx 0,8..120 with vd=idx>>3, done on last -> wb_data byte k = k, wb_valid,
//     err=0, addr = cfg_vd_addr=5'd7.
//   4 lanes, 4 beats each, lane i idx = (4b+i)*8, vd=0xA0+4b+i; lanes finish on different cycles -> WRITE one cycle
//     after final done; wb_data byte k = 0xA0+k.
//   wb_ready held 0 for 5 cycles -> wb_valid/wb_data/wb_vd_addr stable; wb_ready=1 -> IDLE next cycle, busy=0.
//   lane_idx=124 (CHUNK=8) -> chunk dropped, err=1; lanes 0,1 both idx=0 vd 0x11/0x22 -> byte0=0x22, err=1.
//   reset pulsed mid-COLLECT -> busy=0, wb_valid never asserts; start during WRITE ignored; no done for TIMEOUT cycles
//     -> err=1, IDLE, no write-back.

Source files
------------

// File: rtl/vec_wb_collector.sv
// Vector write-back collector: gathers per-lane result chunks into one VLEN-bit
// destination register and hands it to the vreg file over a valid/ready handshake.
module vec_wb_collector #(
    parameter int unsigned VLEN          = 128,
    parameter int unsigned LANE_WIDTH    = 3,
    parameter int unsigned NB_LANE_PORTS = 4,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [4:0]                    cfg_vd_addr,
    input  logic [1:0]                    cfg_nb_lanes,
    input  logic [NB_LANE_PORTS-1:0]      lane_valid,
    input  logic [NB_LANE_PORTS*64-1:0]   lane_vd,
    input  logic [NB_LANE_PORTS*10-1:0]   lane_idx,
    input  logic [NB_LANE_PORTS-1:0]      lane_done,
    output logic                          busy,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [4:0]                    wb_vd_addr,
    output logic [VLEN-1:0]               wb_data,
    output logic                          err
);

    localparam int unsigned CHUNK = 32'd1 << LANE_WIDTH;
    localparam int unsigned VD_W  = 64;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [VLEN-1:0] CHUNK_MASK = ~({VLEN{1'b1}} << CHUNK);

    // DRAIN is the single extra capture cycle after the last lane reports done
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [NB_LANE_PORTS-1:0] act_q;
    logic [NB_LANE_PORTS-1:0] done_q;
    logic [4:0]             addr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [VLEN-1:0]        acc_q;

    logic [NB_LANE_PORTS-1:0] act_c;
    logic [3:0]             nb_act_c;
    logic [VLEN-1:0]        acc_c;
    logic                   hit_err_c;
    logic                   done_all_c;
    logic                   timeout_c;
    logic                   accept_c;
    logic                   collecting_c;
    logic                   load_wb_c;
    logic                   busy_nxt_c;
    logic                   wb_valid_nxt_c;
    logic                   unused_vd;

    // Only the low CHUNK bits of each lane result carry data
    assign unused_vd = ^lane_vd;

    always_comb begin : active_mask
        nb_act_c = 4'd1 << cfg_nb_lanes;
        act_c    = '0;
        for (int i = 0; i < int'(NB_LANE_PORTS); i++) begin
            act_c[i] = (4'(i) < nb_act_c);
        end
    end

    // Lanes applied in ascending order so the higher lane wins on overlapping bits
    always_comb begin : merge_lanes
        logic [VLEN-1:0]  lmask;
        logic [VLEN-1:0]  ldata;
        logic [VLEN-1:0]  claimed;
        logic [IDX_W-1:0] lidx;
        acc_c     = acc_q;
        hit_err_c = 1'b0;
        claimed   = '0;
        lmask     = '0;
        ldata     = '0;
        lidx      = '0;
        for (int i = 0; i < int'(NB_LANE_PORTS); i++) begin
            lmask = '0;
            ldata = '0;
            lidx  = lane_idx[i*IDX_W +: IDX_W];
            if (act_q[i] && lane_valid[i]) begin
                if (32'(lidx) + CHUNK <= VLEN) begin
                    lmask     = CHUNK_MASK << lidx;
                    ldata     = VLEN'(lane_vd[i*VD_W +: CHUNK]) << lidx;
                    hit_err_c = hit_err_c | (|(claimed & lmask));
                    claimed   = claimed | lmask;
                    acc_c     = (acc_c & ~lmask) | ldata;
                end else begin
                    hit_err_c = 1'b1;
                end
            end
        end
    end

    assign done_all_c = (((done_q | lane_done) & act_q) == act_q);
    assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin : next_state_logic
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) next_state = S_COLLECT;
            end
            S_COLLECT: begin
                if (timeout_c)       next_state = S_IDLE;
                else if (done_all_c) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (timeout_c) next_state = S_IDLE;
                else           next_state = S_WRITE;
            end
            S_WRITE: begin
                if (wb_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin : output_logic
        accept_c       = 1'b0;
        collecting_c   = 1'b0;
        load_wb_c      = 1'b0;
        busy_nxt_c     = 1'b0;
        wb_valid_nxt_c = 1'b0;
        accept_c       = (state == S_IDLE) && start;
        collecting_c   = (state == S_COLLECT) || (state == S_DRAIN);
        load_wb_c      = (state == S_DRAIN) && (next_state == S_WRITE);
        busy_nxt_c     = (next_state != S_IDLE);
        wb_valid_nxt_c = (next_state == S_WRITE);
    end

    always_ff @(posedge clk) begin : datapath
        if (reset) begin
            busy       <= 1'b0;
            wb_valid   <= 1'b0;
            wb_vd_addr <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
            act_q      <= '0;
            done_q     <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
        end else begin
            busy     <= busy_nxt_c;
            wb_valid <= wb_valid_nxt_c;
            if (accept_c) begin
                addr_q <= cfg_vd_addr;
                act_q  <= act_c;
                acc_q  <= '0;
                done_q <= '0;
                cnt_q  <= '0;
                err    <= 1'b0;
            end else if (collecting_c) begin
                acc_q  <= acc_c;
                done_q <= done_q | (lane_done & act_q);
                cnt_q  <= cnt_q + CNT_W'(1);
                if (hit_err_c || timeout_c) err <= 1'b1;
            end
            if (load_wb_c) begin
                wb_data    <= acc_c;
                wb_vd_addr <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_vec_wb_collector.sv
// Randomized self-checking bench for vec_wb_collector against a chunk-level reference model.
module tb_vec_wb_collector;

    localparam int unsigned VLEN = 128;
    localparam int unsigned LW   = 3;
    localparam int unsigned NP   = 4;
    localparam int unsigned TO   = 1023;
    localparam int          MAXC = 24;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [4:0]     cfg_vd_addr;
    logic [1:0]     cfg_nb_lanes;
    logic [NP-1:0]  lane_valid;
    logic [NP*64-1:0] lane_vd;
    logic [NP*10-1:0] lane_idx;
    logic [NP-1:0]  lane_done;
    logic           busy;
    logic           wb_valid;
    logic           wb_ready;
    logic [4:0]     wb_vd_addr;
    logic [VLEN-1:0] wb_data;
    logic           err;

    vec_wb_collector #(
        .VLEN(VLEN), .LANE_WIDTH(LW), .NB_LANE_PORTS(NP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_vd_addr(cfg_vd_addr),
        .cfg_nb_lanes(cfg_nb_lanes), .lane_valid(lane_valid), .lane_vd(lane_vd),
        .lane_idx(lane_idx), .lane_done(lane_done), .busy(busy), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_vd_addr(wb_vd_addr), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle stimulus plan for one instruction
    logic [NP-1:0]    s_valid [MAXC];
    logic [NP*64-1:0] s_vd    [MAXC];
    logic [NP*10-1:0] s_idx   [MAXC];
    logic [NP-1:0]    s_done  [MAXC];

    logic [VLEN-1:0] m_acc;
    logic            m_err;
    int              m_last;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk;
        lane_valid = 4'($urandom);
        lane_done  = 4'($urandom);
        lane_vd    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        lane_idx   = 40'({$urandom, $urandom});
    endtask

    // Inactive lanes get random traffic; active lanes start silent
    task automatic clear_stim(input logic [1:0] nb);
        for (int c = 0; c < MAXC; c++) begin
            s_valid[c] = 4'($urandom);
            s_done[c]  = 4'($urandom);
            s_vd[c]    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            s_idx[c]   = 40'({$urandom, $urandom});
            for (int l = 0; l < int'(NP); l++) begin
                if (l < (1 << nb)) begin
                    s_valid[c][l] = 1'b0;
                    s_done[c][l]  = 1'b0;
                end
            end
        end
    endtask

    // Reference: apply byte chunks bit by bit, lanes in ascending order, stop one cycle after all done
    task automatic model(input logic [1:0] nb);
        logic [NP-1:0]   act;
        logic [NP-1:0]   seen;
        logic [VLEN-1:0] wr;
        int idx;
        act = '0;
        for (int l = 0; l < int'(NP); l++) act[l] = (l < (1 << nb));
        m_acc = '0; m_err = 1'b0; seen = '0; m_last = -1;
        for (int c = 0; c < MAXC; c++) begin
            if (m_last >= 0 && c > m_last + 1) break;
            wr = '0;
            for (int l = 0; l < int'(NP); l++) begin
                if (act[l] && s_valid[c][l]) begin
                    idx = int'(s_idx[c][l*10 +: 10]);
                    if (idx + 8 > int'(VLEN)) begin
                        m_err = 1'b1;
                    end else begin
                        for (int b = 0; b < 8; b++) begin
                            if (wr[idx+b]) m_err = 1'b1;
                            wr[idx+b]    = 1'b1;
                            m_acc[idx+b] = s_vd[c][l*64+b];
                        end
                    end
                end
            end
            seen = seen | (s_done[c] & act);
            if (m_last < 0 && seen == act) m_last = c;
        end
    endtask

    task automatic run_txn(input logic [1:0] nb, input logic [4:0] addr, input int hold);
        model(nb);
        cfg_vd_addr  = addr;
        cfg_nb_lanes = nb;
        start        = 1'b1;
        drive_junk();
        tick();
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_err", 128'(err), 128'(0));
        for (int c = 0; c <= m_last + 1 && c < MAXC; c++) begin
            lane_valid   = s_valid[c];
            lane_vd      = s_vd[c];
            lane_idx     = s_idx[c];
            lane_done    = s_done[c];
            start        = 1'($urandom);
            cfg_vd_addr  = 5'($urandom);
            cfg_nb_lanes = 2'($urandom);
            tick();
            if (c <= m_last) chk("early_wbv", 128'(wb_valid), 128'(0));
        end
        start = 1'b0;
        chk("wbv", 128'(wb_valid), 128'(1));
        chk("data", wb_data, m_acc);
        chk("addr", 128'(wb_vd_addr), 128'(addr));
        chk("err", 128'(err), 128'(m_err));
        for (int w = 0; w < hold; w++) begin
            drive_junk();
            start       = 1'b1;
            cfg_vd_addr = 5'($urandom);
            tick();
            chk("hold_wbv", 128'(wb_valid), 128'(1));
            chk("hold_data", wb_data, m_acc);
            chk("hold_addr", 128'(wb_vd_addr), 128'(addr));
            chk("hold_err", 128'(err), 128'(m_err));
        end
        start    = 1'b0;
        wb_ready = 1'b1;
        drive_junk();
        tick();
        wb_ready = 1'b0;
        chk("post_wbv", 128'(wb_valid), 128'(0));
        chk("post_busy", 128'(busy), 128'(0));
        chk("post_data", wb_data, m_acc);
        chk("post_err", 128'(err), 128'(m_err));
    endtask

    initial begin
        logic [VLEN-1:0] expv;
        logic [1:0]      nb;
        int d;
        int busy_cycles;
        logic saw;

        reset = 1'b1; start = 1'b0; cfg_vd_addr = '0; cfg_nb_lanes = '0; wb_ready = 1'b0;
        lane_valid = '0; lane_vd = '0; lane_idx = '0; lane_done = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_wbv", 128'(wb_valid), 128'(0));
        chk("rst_addr", 128'(wb_vd_addr), 128'(0));
        chk("rst_data", wb_data, 128'(0));
        chk("rst_err", 128'(err), 128'(0));

        // One lane, 16 byte chunks, byte k = k
        clear_stim(2'd0);
        for (int k = 0; k < 16; k++) begin
            s_valid[k][0]     = 1'b1;
            s_idx[k][9:0]     = 10'(k * 8);
            s_vd[k][7:0]      = 8'(k);
        end
        s_done[15][0] = 1'b1;
        run_txn(2'd0, 5'd7, 2);
        for (int k = 0; k < 16; k++) expv[k*8 +: 8] = 8'(k);
        chk("t1_bytes", wb_data, expv);

        // Four lanes, staggered beats, lane i done at cycle 3+i
        clear_stim(2'd2);
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 4; b++) begin
                s_valid[b+i][i]           = 1'b1;
                s_idx[b+i][i*10 +: 10]    = 10'((4*b + i) * 8);
                s_vd[b+i][i*64 +: 8]      = 8'(8'hA0 + 4*b + i);
            end
            s_done[3+i][i] = 1'b1;
        end
        run_txn(2'd2, 5'd19, 5);
        for (int k = 0; k < 16; k++) expv[k*8 +: 8] = 8'(8'hA0 + k);
        chk("t2_bytes", wb_data, expv);

        // Out-of-range chunk is dropped
        clear_stim(2'd0);
        s_valid[0][0] = 1'b1; s_idx[0][9:0] = 10'd124; s_vd[0][7:0] = 8'h55; s_done[0][0] = 1'b1;
        run_txn(2'd0, 5'd3, 1);
        chk("t3_data", wb_data, 128'(0));
        chk("t3_err", 128'(err), 128'(1));

        // Same-cycle collision: higher lane wins
        clear_stim(2'd1);
        s_valid[0][1:0] = 2'b11; s_idx[0][19:0] = 20'd0;
        s_vd[0][7:0] = 8'h11; s_vd[0][71:64] = 8'h22; s_done[0][1:0] = 2'b11;
        run_txn(2'd1, 5'd30, 3);
        chk("t4_data", wb_data, 128'h22);
        chk("t4_err", 128'(err), 128'(1));

        // Reset in the middle of a collection abandons it
        cfg_nb_lanes = 2'd2; cfg_vd_addr = 5'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_junk();
            lane_done = '0;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_wbv", 128'(wb_valid), 128'(0));
        chk("mid_rst_err", 128'(err), 128'(0));
        chk("mid_rst_data", wb_data, 128'(0));
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_junk();
            lane_done = '1;
            tick();
            if (wb_valid || busy) saw = 1'b1;
        end
        chk("mid_rst_quiet", 128'(saw), 128'(0));

        // Randomized instructions
        for (int t = 0; t < 20; t++) begin
            nb = 2'($urandom);
            clear_stim(nb);
            for (int l = 0; l < int'(NP); l++) begin
                if (l < (1 << nb)) begin
                    d = int'($urandom_range(0, 12));
                    for (int c = 0; c < MAXC; c++) begin
                        s_valid[c][l] = 1'($urandom);
                        s_done[c][l]  = (c == d) || ((c > d) && ($urandom_range(0, 3) == 0));
                        if ($urandom_range(0, 7) == 0)
                            s_idx[c][l*10 +: 10] = 10'($urandom_range(0, 1023));
                        else
                            s_idx[c][l*10 +: 10] = 10'($urandom_range(0, 15) * 8);
                    end
                end
            end
            run_txn(nb, 5'($urandom), int'($urandom_range(0, 3)));
        end

        // No done ever arrives: forced abort after TIMEOUT collection cycles
        cfg_nb_lanes = 2'd0; cfg_vd_addr = 5'd12; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        saw = 1'b0;
        for (int k = 1; k <= int'(TO) + 5; k++) begin
            drive_junk();
            lane_done[0] = 1'b0;
            tick();
            if (wb_valid) saw = 1'b1;
            if (!busy) begin
                busy_cycles = k;
                break;
            end
        end
        chk("to_cycles", 128'(busy_cycles), 128'(TO));
        chk("to_err", 128'(err), 128'(1));
        chk("to_no_wb", 128'(saw), 128'(0));
        for (int k = 0; k < 3; k++) begin
            drive_junk();
            tick();
            if (wb_valid || busy) saw = 1'b1;
        end
        chk("to_idle", 128'(saw), 128'(0));

        // Next instruction clears the sticky error
        clear_stim(2'd3);
        for (int l = 0; l < int'(NP); l++) begin
            s_valid[l][l]          = 1'b1;
            s_idx[l][l*10 +: 10]   = 10'(l * 32);
            s_vd[l][l*64 +: 8]     = 8'(8'h40 + l);
            s_done[l][l]           = 1'b1;
        end
        run_txn(2'd3, 5'd31, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
